// File: rtl/pipe_ctrl_fwd.sv
// ID-stage decoder, PC adder and EXE-stage forwarding select for the 5-stage pipeline.
// Everything is combinational except a sticky illegal-decode flag kept for debug.
module pipe_ctrl_fwd #(
    parameter int unsigned WORD_LEN     = 32,
    parameter int unsigned REG_ADDR_LEN = 5
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [WORD_LEN-1:0]     pc_in,
    input  logic [WORD_LEN-1:0]     pc_add_value,
    output logic [WORD_LEN-1:0]     pc_next,
    input  logic [WORD_LEN-1:0]     instruction,
    output logic                    WB_en,
    output logic                    MEM_read,
    output logic                    MEM_write,
    output logic [2:0]              EXE_function,
    output logic [1:0]              is_br,
    output logic                    immediate,
    input  logic [REG_ADDR_LEN-1:0] EXE_src1,
    input  logic [REG_ADDR_LEN-1:0] EXE_src2,
    input  logic [REG_ADDR_LEN-1:0] EXE_dest,
    input  logic [REG_ADDR_LEN-1:0] MEM_dest,
    input  logic [REG_ADDR_LEN-1:0] WB_dest,
    input  logic                    EXE_MEM_write,
    input  logic                    MEM_WB_en,
    input  logic                    WB_en_in,
    output logic [1:0]              forward_signal_mux_1,
    output logic [1:0]              forward_signal_mux_2_3,
    output logic                    illegal_seen
);

    localparam logic [5:0] OpRtype = 6'b000000;
    localparam logic [5:0] OpAddi  = 6'b001000;
    localparam logic [5:0] OpLw    = 6'b100011;
    localparam logic [5:0] OpSw    = 6'b101011;
    localparam logic [5:0] OpBeq   = 6'b000100;
    localparam logic [5:0] OpBne   = 6'b000101;
    localparam logic [5:0] OpJ     = 6'b000010;

    localparam logic [2:0] AluAdd = 3'b000;
    localparam logic [2:0] AluSub = 3'b001;
    localparam logic [2:0] AluAnd = 3'b010;
    localparam logic [2:0] AluOr  = 3'b011;
    localparam logic [2:0] AluNor = 3'b100;
    localparam logic [2:0] AluXor = 3'b101;
    localparam logic [2:0] AluSlt = 3'b110;

    localparam logic [1:0] FwdRegFile = 2'd0;
    localparam logic [1:0] FwdMem     = 2'd1;
    localparam logic [1:0] FwdWb      = 2'd2;

    logic [5:0] opcode;
    logic [5:0] funct;
    logic       illegal;
    logic       illegal_seen_q;
    logic       illegal_seen_d;

    assign opcode  = instruction[31:26];
    assign funct   = instruction[5:0];
    assign pc_next = pc_in + pc_add_value;

    always_comb begin
        WB_en        = 1'b0;
        MEM_read     = 1'b0;
        MEM_write    = 1'b0;
        EXE_function = AluAdd;
        is_br        = 2'd0;
        immediate    = 1'b0;
        illegal      = 1'b0;
        case (opcode)
            OpRtype: begin
                // The all-zero word is the canonical NOP, not an unknown funct.
                if (instruction != '0) begin
                    WB_en = 1'b1;
                    case (funct)
                        6'b100000: EXE_function = AluAdd;
                        6'b100010: EXE_function = AluSub;
                        6'b100100: EXE_function = AluAnd;
                        6'b100101: EXE_function = AluOr;
                        6'b100111: EXE_function = AluNor;
                        6'b100110: EXE_function = AluXor;
                        6'b101010: EXE_function = AluSlt;
                        default: begin
                            WB_en   = 1'b0;
                            illegal = 1'b1;
                        end
                    endcase
                end
            end
            OpAddi: begin
                WB_en     = 1'b1;
                immediate = 1'b1;
            end
            OpLw: begin
                WB_en     = 1'b1;
                MEM_read  = 1'b1;
                immediate = 1'b1;
            end
            OpSw: begin
                MEM_write = 1'b1;
                immediate = 1'b1;
            end
            OpBeq:   is_br = 2'd2;
            OpBne:   is_br = 2'd3;
            OpJ:     is_br = 2'd1;
            default: illegal = 1'b1;
        endcase
    end

    // MEM is the younger producer, so it wins over WB; r0 is never bypassed.
    always_comb begin
        forward_signal_mux_1 = FwdRegFile;
        if (MEM_WB_en && (MEM_dest != '0) && (MEM_dest == EXE_src1)) begin
            forward_signal_mux_1 = FwdMem;
        end else if (WB_en_in && (WB_dest != '0) && (WB_dest == EXE_src1)) begin
            forward_signal_mux_1 = FwdWb;
        end

        forward_signal_mux_2_3 = FwdRegFile;
        if (MEM_WB_en && (MEM_dest != '0) && (MEM_dest == EXE_src2)) begin
            forward_signal_mux_2_3 = FwdMem;
        end else if (WB_en_in && (WB_dest != '0) && (WB_dest == EXE_src2)) begin
            forward_signal_mux_2_3 = FwdWb;
        end
    end

    assign illegal_seen_d = illegal_seen_q | illegal;

    always_ff @(posedge clk) begin
        if (rst) begin
            illegal_seen_q <= 1'b0;
        end else begin
            illegal_seen_q <= illegal_seen_d;
        end
    end

    assign illegal_seen = illegal_seen_q;

    // Kept on the interface for pipeline compatibility; they do not influence any output.
    logic unused_inputs;
    assign unused_inputs = ^{EXE_dest, EXE_MEM_write};

endmodule

// File: tb/tb_pipe_ctrl_fwd.sv
// Directed self-checking bench for pipe_ctrl_fwd: adder, decoder, forwarding and sticky flag.
module tb_pipe_ctrl_fwd;

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] pc_in, pc_add_value, pc_next, instruction;
    logic        WB_en, MEM_read, MEM_write, immediate, illegal_seen;
    logic [2:0]  EXE_function;
    logic [1:0]  is_br, forward_signal_mux_1, forward_signal_mux_2_3;
    logic [4:0]  EXE_src1, EXE_src2, EXE_dest, MEM_dest, WB_dest;
    logic        EXE_MEM_write, MEM_WB_en, WB_en_in;

    int vectors    = 0;
    int miscompares = 0;

    always #5 clk = ~clk;

    pipe_ctrl_fwd dut (
        .clk                    (clk),
        .rst                    (rst),
        .pc_in                  (pc_in),
        .pc_add_value           (pc_add_value),
        .pc_next                (pc_next),
        .instruction            (instruction),
        .WB_en                  (WB_en),
        .MEM_read               (MEM_read),
        .MEM_write              (MEM_write),
        .EXE_function           (EXE_function),
        .is_br                  (is_br),
        .immediate              (immediate),
        .EXE_src1               (EXE_src1),
        .EXE_src2               (EXE_src2),
        .EXE_dest               (EXE_dest),
        .MEM_dest               (MEM_dest),
        .WB_dest                (WB_dest),
        .EXE_MEM_write          (EXE_MEM_write),
        .MEM_WB_en              (MEM_WB_en),
        .WB_en_in               (WB_en_in),
        .forward_signal_mux_1   (forward_signal_mux_1),
        .forward_signal_mux_2_3 (forward_signal_mux_2_3),
        .illegal_seen           (illegal_seen)
    );

    // Packed decoder view: {WB_en, MEM_read, MEM_write, immediate, EXE_function, is_br}
    logic [8:0] dec;
    assign dec = {WB_en, MEM_read, MEM_write, immediate, EXE_function, is_br};

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic decode(input string tag, input logic [31:0] instr, input logic [8:0] exp);
        @(negedge clk);
        instruction = instr;
        #1;
        check(tag, {23'd0, dec}, {23'd0, exp});
    endtask

    task automatic fwd(input logic [4:0] s1, input logic [4:0] s2, input logic [4:0] md,
                       input logic men, input logic [4:0] wd, input logic wen,
                       input logic [1:0] exp1, input logic [1:0] exp2, input string tag);
        EXE_src1  = s1;
        EXE_src2  = s2;
        MEM_dest  = md;
        MEM_WB_en = men;
        WB_dest   = wd;
        WB_en_in  = wen;
        #1;
        check({tag, "_mux1"}, {30'd0, forward_signal_mux_1}, {30'd0, exp1});
        check({tag, "_mux23"}, {30'd0, forward_signal_mux_2_3}, {30'd0, exp2});
    endtask

    initial begin
        rst = 1'b1;
        pc_in = '0; pc_add_value = '0; instruction = '0;
        EXE_src1 = '0; EXE_src2 = '0; EXE_dest = 5'd7; MEM_dest = '0; WB_dest = '0;
        EXE_MEM_write = 1'b1; MEM_WB_en = 1'b0; WB_en_in = 1'b0;

        @(posedge clk); #1;
        check("reset_flag", {31'd0, illegal_seen}, 32'd0);
        check("nop_dec", {23'd0, dec}, 32'd0);
        @(negedge clk);
        rst = 1'b0;

        // Adder
        pc_in = 32'h10; pc_add_value = 32'h1; #1;
        check("pc_inc", pc_next, 32'h11);
        pc_add_value = 32'hFFFF_FFFE; #1;
        check("pc_neg", pc_next, 32'h0E);
        pc_in = 32'hFFFF_FFFF; pc_add_value = 32'h1; #1;
        check("pc_wrap", pc_next, 32'h0);

        // Decoder
        decode("lw",   32'h8C22_0004, 9'b1101_000_00);
        decode("sw",   32'hAC22_0004, 9'b0011_000_00);
        decode("addi", 32'h2022_0005, 9'b1001_000_00);
        decode("add",  32'h0043_0820, 9'b1000_000_00);
        decode("sub",  32'h0043_0822, 9'b1000_001_00);
        decode("and",  32'h0043_0824, 9'b1000_010_00);
        decode("or",   32'h0043_0825, 9'b1000_011_00);
        decode("nor",  32'h0043_0827, 9'b1000_100_00);
        decode("xor",  32'h0043_0826, 9'b1000_101_00);
        decode("slt",  32'h0043_082A, 9'b1000_110_00);
        decode("beq",  32'h1022_0003, 9'b0000_000_10);
        decode("bne",  32'h1422_0003, 9'b0000_000_11);
        decode("j",    32'h0800_0005, 9'b0000_000_01);
        check("flag_after_legal", {31'd0, illegal_seen}, 32'd0);

        // Forwarding
        fwd(5'd3, 5'd0, 5'd3, 1'b1, 5'd3, 1'b1, 2'd1, 2'd0, "mem_prio");
        fwd(5'd3, 5'd0, 5'd3, 1'b0, 5'd3, 1'b1, 2'd2, 2'd0, "wb_only");
        fwd(5'd1, 5'd0, 5'd0, 1'b1, 5'd0, 1'b1, 2'd0, 2'd0, "r0_never");
        fwd(5'd1, 5'd5, 5'd9, 1'b1, 5'd5, 1'b0, 2'd0, 2'd0, "wb_disabled");
        fwd(5'd4, 5'd6, 5'd6, 1'b1, 5'd4, 1'b1, 2'd2, 2'd1, "split");
        fwd(5'd2, 5'd8, 5'd8, 1'b1, 5'd8, 1'b1, 2'd0, 2'd1, "src2_prio");

        // Sticky illegal flag
        decode("illegal_op_dec", 32'hFC00_0000, 9'd0);
        check("flag_before_edge", {31'd0, illegal_seen}, 32'd0);
        @(posedge clk); #1;
        check("flag_set", {31'd0, illegal_seen}, 32'd1);
        decode("lw_after", 32'h8C22_0004, 9'b1101_000_00);
        @(posedge clk); #1;
        check("flag_sticky", {31'd0, illegal_seen}, 32'd1);
        decode("nop", 32'h0000_0000, 9'd0);
        @(posedge clk); #1;
        check("flag_nop", {31'd0, illegal_seen}, 32'd1);

        // Reset wins over a simultaneous illegal decode
        @(negedge clk);
        rst = 1'b1;
        instruction = 32'hFC00_0000;
        @(posedge clk); #1;
        check("rst_prio", {31'd0, illegal_seen}, 32'd0);
        check("rst_no_comb", {23'd0, dec}, 32'd0);
        @(negedge clk);
        rst = 1'b0;
        instruction = 32'h0000_0000;
        @(posedge clk); #1;
        check("nop_no_set", {31'd0, illegal_seen}, 32'd0);

        // R-type with an unlisted funct is illegal
        decode("bad_funct_dec", 32'h0043_0821, 9'd0);
        @(posedge clk); #1;
        check("bad_funct_flag", {31'd0, illegal_seen}, 32'd1);

        // Combinational outputs ignore rst
        @(negedge clk);
        rst = 1'b1;
        instruction = 32'h0043_0822;
        pc_in = 32'h100; pc_add_value = 32'h4; #1;
        check("rst_dec", {23'd0, dec}, {23'd0, 9'b1000_001_00});
        check("rst_pc", pc_next, 32'h104);
        @(posedge clk); #1;
        check("rst_clear", {31'd0, illegal_seen}, 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/pipe_ctrl_fwd.md
Name: pipe_ctrl_fwd

Overview:
- Control and datapath-helper block of the 5-stage MIPS pipeline, integrating three sub-functions: alu_plus (PC adder), control_unit (ID-stage decoder) and forwarding_unit (EXE-stage bypass select).
- All datapath/control outputs are combinational.
- The only state is a sticky illegal-opcode flag for debug.

Parameters:
WORD_LEN, 32, datapath/instruction width
REG_ADDR_LEN, 5, register index width

Ports:
clk  in  1  clock
rst  in  1  reset, synchronous, active-high
pc_in  in  32  current PC (word address)
pc_add_value  in  32  increment or sign-extended branch offset
pc_next  out  32  pc_in + pc_add_value
instruction  in  32  ID-stage instruction
WB_en  out  1  writeback enable
MEM_read  out  1  load
MEM_write  out  1  store
EXE_function  out  3  ALU operation
is_br  out  2  0 none, 1 jmp, 2 beq, 3 bne
immediate  out  1  select sign-extended imm[15:0] as ALU operand 2
EXE_src1  in  5  rs of EXE instruction
EXE_src2  in  5  rt of EXE instruction
EXE_dest  in  5  EXE destination (accepted, no effect)
MEM_dest  in  5  MEM-stage destination
WB_dest  in  5  WB-stage destination
EXE_MEM_write  in  1  EXE is a store (accepted, no effect)
MEM_WB_en  in  1  MEM-stage writeback enable
WB_en_in  in  1  WB-stage writeback enable
forward_signal_mux_1  out  2  ALU src1 select
forward_signal_mux_2_3  out  2  ALU src2 / store-value select
illegal_seen  out  1  sticky: an undefined opcode/funct was decoded

Behaviour:
- Adder:
  - pc_next = pc_in + pc_add_value.
  - Unsigned, modulo 2^32; carry discarded; zero latency.
- Decoder (combinational on instruction[31:26] opcode and [5:0] funct):
  - Default for all decoder outputs is 0.
  - EXE_function codes: 000 add, 001 sub, 010 and, 011 or, 100 nor, 101 xor, 110 slt, 111 unused.
  - R-type (opcode 000000): WB_en=1, immediate=0. funct mapping:
    - 100000 add
    - 100010 sub
    - 100100 and
    - 100101 or
    - 100111 nor
    - 100110 xor
    - 101010 slt
  - addi 001000: WB_en=1, immediate=1, add.
  - lw 100011: WB_en=1, MEM_read=1, immediate=1, add.
  - sw 101011: MEM_write=1, immediate=1, add.
  - beq 000100: is_br=2. bne 000101: is_br=3. j 000010: is_br=1. All other decoder outputs 0 for these three.
  - instruction==32'h0 is NOP: all outputs 0, not illegal.
  - Any other opcode, or an R-type with unlisted funct: all outputs 0, illegal.
- Forwarding (combinational):
  - src1:
    - if MEM_WB_en && MEM_dest!=0 && MEM_dest==EXE_src1 then 1 (from MEM);
    - else if WB_en_in && WB_dest!=0 && WB_dest==EXE_src1 then 2 (from WB);
    - else 0 (register file).
  - src2: same rule using EXE_src2, driving forward_signal_mux_2_3.
  - Evaluated for every instruction type.
  - MEM has priority over WB when both match.
  - Register 0 is never forwarded.
  - Value 3 is never produced.
- illegal_seen:
  - Set at posedge clk when the decode is illegal; stays set.
  - rst=1 at posedge clears it to 0; rst has priority over the set.
  - Reset value 0.
- rst does not affect any combinational output.

Test Plan:
1. Adder: pc_in=0x10, pc_add_value=1 -> pc_next=0x11. pc_in=0x10, pc_add_value=0xFFFFFFFE -> pc_next=0x0E. pc_in=0xFFFFFFFF, pc_add_value=1 -> pc_next=0 (wrap).
2. Decode:
   - 0x8C220004 (lw) -> WB_en=1, MEM_read=1, MEM_write=0, immediate=1, EXE_function=000, is_br=0.
   - 0xAC220004 (sw) -> MEM_write=1, WB_en=0.
   - 0x00430822 (sub) -> WB_en=1, EXE_function=001, immediate=0.
3. Branch decode: 0x10220003 -> is_br=2; 0x14220003 -> is_br=3; 0x08000005 -> is_br=1. All three have WB_en=MEM_read=MEM_write=0.
4. Forwarding:
   - EXE_src1=3, MEM_dest=3, MEM_WB_en=1, WB_dest=3, WB_en_in=1 -> mux_1=1.
   - With MEM_WB_en=0 -> mux_1=2.
   - EXE_src2=0, MEM_dest=0, MEM_WB_en=1 -> mux_2_3=0.
   - EXE_src2=5, WB_dest=5, WB_en_in=0 -> mux_2_3=0.
5. Illegal flag:
   - rst=1 for one cycle -> illegal_seen=0.
   - Apply opcode 111111 for one cycle -> illegal_seen=1 after the edge, stays 1 after valid instructions.
   - Assert rst -> 0 at the next edge.
   - 0x00000000 -> outputs 0, flag unchanged.
